instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Decoupling queue between instruction fetch and instruction decode. Captures each fetched {pc, instr} pair into a small circular FIFO so that a decode stall does not discard fetched instructions. Presents the oldest entry to decode with a valid flag and injects a NOP whenever it is empty. Supports a single-cycle flush on branch redirect.

## Interface
- DEPTH, 4: number of entries; power of two, 2..16.
- XLEN, 32: width of pc and instruction words.
- NOP_INSTR, 32'h0000_0013: instruction driven on `instr_o` when no valid entry is presented (addi x0,x0,0).
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- push_i  input  1  fetch offers `{push_pc_i, push_instr_i}` this cycle.
- push_pc_i  input  XLEN  pc of offered instruction.
- push_instr_i  input  XLEN  offered instruction word.
- full_o  output  1  queue holds DEPTH entries; fetch must hold its pc (drives fetch pc enable low).
- pop_i  input  1  decode consumes the head entry this cycle.
- flush_i  input  1  discard all entries (branch taken / redirect).
- valid_o  output  1  head entry is valid.
- pc_o  output  XLEN  head pc; 0 when `valid_o`=0.
- instr_o  output  XLEN  head instruction; NOP_INSTR when `valid_o`=0.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- drop_o  output  1  one-cycle pulse: a push was refused (push while full, or push during flush).

## Operation
- Storage: DEPTH-entry arrays for pc and instr, write pointer, read pointer (each $clog2(DEPTH) bits, wrap modulo DEPTH), occupancy counter.
- Accept condition: push_acc = push_i & ~flush_i & (count < DEPTH). Full is judged on the registered count only; a same-cycle pop does not free a slot for a push (no combinational path pop_i -> full_o).
- Pop condition: pop_acc = pop_i & ~flush_i & (count != 0). Pop while empty is ignored; no state change.
- push_acc: write entry at wptr, wptr+1.
- pop_acc: rptr+1.
- count update: +1 push only, -1 pop only, unchanged for both or neither.
- Flush has absolute priority: wptr, rptr, count cleared to 0 on the next edge; same-cycle push and pop are ignored; drop_o=1 if push_i was high.
- drop_o = push_i & (flush_i | count==DEPTH), registered (appears the cycle after the refused push).
- Outputs are first-word-fall-through from storage: valid_o = (count != 0); pc_o/instr_o = entry[rptr] when valid, else 0/NOP_INSTR. Decoded from registered state only (no input-to-output combinational path).
- full_o = (count == DEPTH).
- Storage contents are not reset; only pointers, count and drop_o.

## Timing
- Reset (rst_ni=0, asynchronous): count_o=0, valid_o=0, full_o=0, pc_o=0, instr_o=NOP_INSTR, drop_o=0, pointers=0. Reset mid-operation discards all entries immediately without waiting for a clock edge.
- Latency: an entry pushed at edge N is visible on valid_o/pc_o/instr_o after edge N (next cycle), even if queue was empty. No bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- At count==DEPTH with push_i & pop_i: pop accepted, push refused (drop_o next cycle), count becomes DEPTH-1.
- At count==0 with push_i & pop_i: push accepted, pop ignored, count becomes 1.
- Pointer wrap: after DEPTH pushes wptr returns to 0; ordering preserved across wrap.
- Flush: queue empty (valid_o=0, instr_o=NOP) the cycle after flush_i is sampled.

## Test plan
- Reset then idle: after rst_ni released, valid_o=0, instr_o=32'h00000013, pc_o=0, count_o=0, full_o=0.
- Fill: push pc 0x00,0x04,0x08,0x0C with instr 0xA0..0xA3, pop_i=0 -> count_o=4, full_o=1; fifth push (pc 0x10) -> drop_o pulses 1 cycle, count stays 4; then pop 4 times -> heads 0x00,0x04,0x08,0x0C in order, then valid_o=0.
- Streaming wrap: push and pop every cycle for 10 cycles, pc 0x100 step 4 -> count_o stays 1, pc_o lags pushed pc by one cycle, no drop_o, pointers wrap twice.
- Full with simultaneous push/pop: at count 4, assert push (pc 0x200) and pop -> head advances, drop_o=1, count_o=3; pc 0x200 never appears.
- Flush: with count 3, assert flush_i with push_i and pop_i -> next cycle count_o=0, valid_o=0, instr_o=NOP, drop_o=1; subsequent push pc 0x300 appears as head next cycle.
- Async reset mid-stream: with count 2, drop rst_ni between edges -> valid_o=0, count_o=0 immediately, before next clock edge.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: decoupling FIFO between instruction fetch and decode.
// Each fetched {pc, instr} pair goes into a small circular buffer. The oldest
// entry is presented to decode first-word-fall-through, and a NOP is shown
// while the buffer is empty. A flush on branch redirect empties the buffer
// in a single cycle.
module instr_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [XLEN-1:0]          push_pc_i,
  input  logic [XLEN-1:0]          push_instr_i,
  output logic                     full_o,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [XLEN-1:0]          instr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;
  logic            drop_q;

  logic is_full;
  logic is_empty;
  logic push_acc;
  logic pop_acc;

  // Accept/refuse decisions; fullness comes from the registered count only,
  // so a same-cycle pop never frees a slot for a push.
  always_comb begin
    is_full  = (count_q == FULL_CNT);
    is_empty = (count_q == '0);
    push_acc = push_i & ~flush_i & ~is_full;
    pop_acc  = pop_i  & ~flush_i & ~is_empty;
  end

  // Entry storage: written at the write pointer on an accepted push.
  // NOTE: the storage arrays have no reset; valid_o gates every read, so
  // stale contents are never visible and the arrays can map to plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      pc_mem[wptr_q]    <= push_pc_i;
      instr_mem[wptr_q] <= push_instr_i;
    end
  end

  // Pointers, occupancy and the refused-push pulse; flush has priority.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= push_i & (flush_i | is_full);
      if (flush_i) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push_acc) wptr_q <= wptr_q + AW'(1);
        if (pop_acc)  rptr_q <= rptr_q + AW'(1);
        case ({push_acc, pop_acc})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Head presentation decoded purely from registered state.
  always_comb begin
    valid_o = ~is_empty;
    full_o  = is_full;
    count_o = count_q;
    drop_o  = drop_q;
    pc_o    = '0;
    instr_o = XLEN'(NOP_INSTR);
    if (valid_o) begin
      pc_o    = pc_mem[rptr_q];
      instr_o = instr_mem[rptr_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: directed scenarios plus random traffic,
// checked each cycle against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          XLEN  = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            push_i = 1'b0;
  logic [XLEN-1:0] push_pc_i = '0;
  logic [XLEN-1:0] push_instr_i = '0;
  logic            pop_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            full_o;
  logic            valid_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] instr_o;
  logic [2:0]      count_o;
  logic            drop_o;

  instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_INSTR(NOP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_i(push_i), .push_pc_i(push_pc_i), .push_instr_i(push_instr_i),
    .full_o(full_o), .pop_i(pop_i), .flush_i(flush_i),
    .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o),
    .count_o(count_o), .drop_o(drop_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t model_q[$];
  logic   exp_drop = 1'b0;
  bit     mon_en = 1'b0;
  int     vectors = 0;
  int     miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending instructions updated by the
  // queue rules each edge (refuse when full or flushing, ignore pop on empty).
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      model_q.delete();
      exp_drop = 1'b0;
    end else begin
      automatic bit was_full  = (model_q.size() == DEPTH);
      automatic bit was_empty = (model_q.size() == 0);
      exp_drop = push_i & (flush_i | was_full);
      if (flush_i) begin
        model_q.delete();
      end else begin
        if (pop_i && !was_empty) void'(model_q.pop_front());
        if (push_i && !was_full) model_q.push_back({push_pc_i, push_instr_i});
      end
    end
  end

  // Monitor: mid-cycle comparison of everything the DUT presents.
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("mon_count", 64'(count_o), 64'(model_q.size()));
      check("mon_valid", 64'(valid_o), 64'(model_q.size() != 0));
      check("mon_full",  64'(full_o),  64'(model_q.size() == DEPTH));
      check("mon_drop",  64'(drop_o),  64'(exp_drop));
      if (model_q.size() != 0) begin
        check("mon_head_pc",    64'(pc_o),    64'(model_q[0].pc));
        check("mon_head_instr", 64'(instr_o), 64'(model_q[0].instr));
      end else begin
        check("mon_idle_pc",    64'(pc_o),    64'(0));
        check("mon_idle_instr", 64'(instr_o), 64'(NOP));
      end
    end
  end

  // Drive one cycle of inputs just after an edge, then step past the next edge.
  task automatic cycle(input bit push, input logic [31:0] pc, input logic [31:0] instr,
                       input bit pop, input bit flush);
    push_i       = push;
    push_pc_i    = pc;
    push_instr_i = instr;
    pop_i        = pop;
    flush_i      = flush;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    mon_en = 1'b1;

    // Reset then idle.
    check("rst_valid", 64'(valid_o), 64'(0));
    check("rst_instr", 64'(instr_o), 64'h13);
    check("rst_pc",    64'(pc_o),    64'(0));
    check("rst_count", 64'(count_o), 64'(0));
    check("rst_full",  64'(full_o),  64'(0));
    idle();

    // Fill, refused fifth push, drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
    check("fill_count", 64'(count_o), 64'(4));
    check("fill_full",  64'(full_o),  64'(1));
    cycle(1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
    check("fill_drop",   64'(drop_o),  64'(1));
    check("fill_count5", 64'(count_o), 64'(4));
    idle();
    check("fill_drop_end", 64'(drop_o), 64'(0));
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(pc_o), 64'(4 * i));
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check("drain_valid", 64'(valid_o), 64'(0));

    // Streaming push+pop every cycle; pointers wrap twice.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h100 + 32'(4 * i), 32'hB00 + 32'(i), 1'b1, 1'b0);
      check("stream_pc",    64'(pc_o),    64'(32'h100 + 32'(4 * i)));
      check("stream_count", 64'(count_o), 64'(1));
      check("stream_drop",  64'(drop_o),  64'(0));
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h180 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h200, 32'hDEAD, 1'b1, 1'b0);
    check("fullpp_count", 64'(count_o), 64'(3));
    check("fullpp_drop",  64'(drop_o),  64'(1));
    check("fullpp_head",  64'(pc_o),    64'(32'h184));

    // Flush with push and pop in the same cycle.
    cycle(1'b1, 32'h2FC, 32'hEEEE, 1'b1, 1'b1);
    check("flush_count", 64'(count_o), 64'(0));
    check("flush_valid", 64'(valid_o), 64'(0));
    check("flush_instr", 64'(instr_o), 64'h13);
    check("flush_drop",  64'(drop_o),  64'(1));
    cycle(1'b1, 32'h300, 32'hF00, 1'b0, 1'b0);
    check("post_flush_pc", 64'(pc_o), 64'(32'h300));

    // Asynchronous reset mid-stream at count 2.
    cycle(1'b1, 32'h304, 32'hF01, 1'b0, 1'b0);
    push_i = 1'b0;
    check("pre_rst_count", 64'(count_o), 64'(2));
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_valid", 64'(valid_o), 64'(0));
    check("async_rst_count", 64'(count_o), 64'(0));
    check("async_rst_instr", 64'(instr_o), 64'h13);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 9) < 7), $urandom(), $urandom(),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
    end
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
